// File: rtl/ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_stage                                                      |
// | Purpose  : Pipeline execute stage. Single-cycle integer ALU, branch      |
// |            target adder and EX/MEM output register.                      |
// |            RV32M_EN: when defined, MUL/MULHU/DIV/DIVU/REM/REMU run on    |
// |            an iterative shift-add / restoring-divide engine; otherwise   |
// |            they retire at once as illegal ops.                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  stall_req_o,
  input  logic                  ctrl_wb_RegWrite_i,
  input  logic                  ctrl_wb_Mem2Reg_i,
  input  logic                  ctrl_mem_branch_i,
  input  logic                  ctrl_mem_read_i,
  input  logic                  ctrl_mem_write_i,
  input  logic                  ctrl_ex_AluSrc_i,
  input  logic [1:0]            ctrl_ex_AluOp_i,
  input  logic [DATA_W-1:0]     pc_i,
  input  logic [DATA_W-1:0]     reg1_data_i,
  input  logic [DATA_W-1:0]     reg2_data_i,
  input  logic [DATA_W-1:0]     imm_data_i,
  input  logic [3:0]            alu_op_i,
  input  logic [REG_ADDR_W-1:0] write_addr_i,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     alu_result_o,
  output logic                  zero_o,
  output logic [DATA_W-1:0]     branch_target_o,
  output logic [DATA_W-1:0]     store_data_o,
  output logic                  illegal_o,
  output logic                  ctrl_wb_RegWrite_o,
  output logic                  ctrl_wb_Mem2Reg_o,
  output logic                  ctrl_mem_branch_o,
  output logic                  ctrl_mem_read_o,
  output logic                  ctrl_mem_write_o,
  output logic [REG_ADDR_W-1:0] write_addr_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_val;
  logic [DATA_W-1:0] sc_result;
  logic [DATA_W-1:0] m_result;
  logic [SH_W-1:0]   shamt;
  logic              is_mop;
  logic              accept;
  logic              defer;
  logic              done;
  logic              illegal_op;
  logic              unused_aluop;

  assign op_a         = reg1_data_i;
  assign op_b         = ctrl_ex_AluSrc_i ? imm_data_i : reg2_data_i;
  assign shamt        = op_b[SH_W-1:0];
  // Ops 10..15 (1010..1111) are the M-extension group.
  assign is_mop       = alu_op_i[3] & (alu_op_i[2] | alu_op_i[1]);
  assign accept       = ready_o & valid_i & ~flush_i;
  assign unused_aluop = ^ctrl_ex_AluOp_i;
  assign sc_result    = illegal_op ? '0 : alu_val;

  // Single-cycle integer ALU
  always_comb begin
    alu_val = '0;
    case (alu_op_i)
      4'd0:    alu_val = op_a + op_b;
      4'd1:    alu_val = op_a - op_b;
      4'd2:    alu_val = op_a << shamt;
      4'd3:    alu_val = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
      4'd4:    alu_val = (op_a < op_b) ? DATA_W'(1) : '0;
      4'd5:    alu_val = op_a ^ op_b;
      4'd6:    alu_val = op_a >> shamt;
      4'd7:    alu_val = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_val = op_a | op_b;
      4'd9:    alu_val = op_a & op_b;
      default: alu_val = '0;
    endcase
  end

`ifdef RV32M_EN
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  state_t            state_nx;
  logic [SH_W-1:0]   cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] acc_nx;
  logic [DATA_W-1:0] lo_nx;
  logic [DATA_W-1:0] raw;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_sh;
  logic [2:0]        mop;
  logic              neg_res;
  logic              div_zero;
  logic              last;
  logic              sgn_div;
  logic              a_neg;
  logic              b_neg;

  assign last        = (cnt == SH_W'(DATA_W - 1));
  // DIV (100) and REM (110) are the signed divide ops.
  assign sgn_div     = alu_op_i[2] & ~alu_op_i[0];
  assign a_neg       = sgn_div & op_a[DATA_W-1];
  assign b_neg       = sgn_div & op_b[DATA_W-1];
  assign ready_o     = (state == IDLE);
  assign stall_req_o = (state != IDLE) | (valid_i & is_mop & ~flush_i);
  assign defer       = is_mop;
  assign done        = (state == BUSY) & last & ~flush_i;
  assign illegal_op  = 1'b0;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // FSM next state; flush wins over acceptance and completion
  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (valid_i & is_mop) state_nx = BUSY;
        BUSY:    if (last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // One multiply (shift-add on {acc,lo}) or restoring-divide step
  always_comb begin
    acc_nx  = acc;
    lo_nx   = lo;
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh  = {acc, lo[DATA_W-1]};
    if (mop[2]) begin
      if (div_sh >= {1'b0, opnd}) begin
        acc_nx = DATA_W'(div_sh - {1'b0, opnd});
        lo_nx  = {lo[DATA_W-2:0], 1'b1};
      end else begin
        acc_nx = div_sh[DATA_W-1:0];
        lo_nx  = {lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_nx = mul_sum[DATA_W:1];
      lo_nx  = {mul_sum[0], lo[DATA_W-1:1]};
    end
  end

  // MULHU and REM/REMU come from the upper half, the rest from the lower half
  always_comb begin
    raw      = ((mop == 3'b011) | (mop[2:1] == 2'b11)) ? acc_nx : lo_nx;
    m_result = neg_res ? -raw : raw;
    // Quotient of a divide by zero is all ones regardless of sign
    if (div_zero & (mop[2:1] == 2'b10)) m_result = '1;
  end

  // Operand latch and iteration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      mop      <= '0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept & is_mop) begin
      acc      <= '0;
      lo       <= a_neg ? -op_a : op_a;
      opnd     <= b_neg ? -op_b : op_b;
      mop      <= alu_op_i[2:0];
      div_zero <= (op_b == '0);
      // REM takes the dividend sign, DIV the xor of both signs
      neg_res  <= alu_op_i[1] ? a_neg : (a_neg ^ b_neg);
      cnt      <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nx;
      lo  <= lo_nx;
      cnt <= cnt + SH_W'(1);
    end
  end
`else
  assign ready_o     = 1'b1;
  assign stall_req_o = 1'b0;
  assign defer       = 1'b0;
  assign done        = 1'b0;
  assign m_result    = '0;
  assign illegal_op  = is_mop;
`endif

  // EX/MEM output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o            <= 1'b0;
      alu_result_o       <= '0;
      zero_o             <= 1'b0;
      branch_target_o    <= '0;
      store_data_o       <= '0;
      illegal_o          <= 1'b0;
      ctrl_wb_RegWrite_o <= 1'b0;
      ctrl_wb_Mem2Reg_o  <= 1'b0;
      ctrl_mem_branch_o  <= 1'b0;
      ctrl_mem_read_o    <= 1'b0;
      ctrl_mem_write_o   <= 1'b0;
      write_addr_o       <= '0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        ctrl_wb_RegWrite_o <= ctrl_wb_RegWrite_i & ~illegal_op;
        ctrl_wb_Mem2Reg_o  <= ctrl_wb_Mem2Reg_i;
        ctrl_mem_branch_o  <= ctrl_mem_branch_i;
        ctrl_mem_read_o    <= ctrl_mem_read_i;
        ctrl_mem_write_o   <= ctrl_mem_write_i;
        write_addr_o       <= write_addr_i;
        store_data_o       <= reg2_data_i;
        branch_target_o    <= pc_i + imm_data_i;
        illegal_o          <= illegal_op;
        if (!defer) begin
          valid_o      <= 1'b1;
          alu_result_o <= sc_result;
          zero_o       <= (sc_result == '0);
        end
      end else if (done) begin
        valid_o      <= 1'b1;
        alu_result_o <= m_result;
        zero_o       <= (m_result == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ex_stage                                                   |
// | Purpose  : Self-checking bench for ex_stage (honours RV32M_EN).          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ex_stage;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o, stall_req_o;
  logic        ctrl_wb_RegWrite_i = 1'b0, ctrl_wb_Mem2Reg_i = 1'b0;
  logic        ctrl_mem_branch_i = 1'b0, ctrl_mem_read_i = 1'b0, ctrl_mem_write_i = 1'b0;
  logic        ctrl_ex_AluSrc_i = 1'b0;
  logic [1:0]  ctrl_ex_AluOp_i = 2'b0;
  logic [31:0] pc_i = '0, reg1_data_i = '0, reg2_data_i = '0, imm_data_i = '0;
  logic [3:0]  alu_op_i = '0;
  logic [4:0]  write_addr_i = '0;
  logic        valid_o, zero_o, illegal_o;
  logic [31:0] alu_result_o, branch_target_o, store_data_o;
  logic        ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o;
  logic        ctrl_mem_read_o, ctrl_mem_write_o;
  logic [4:0]  write_addr_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .stall_req_o(stall_req_o),
    .ctrl_wb_RegWrite_i(ctrl_wb_RegWrite_i), .ctrl_wb_Mem2Reg_i(ctrl_wb_Mem2Reg_i),
    .ctrl_mem_branch_i(ctrl_mem_branch_i), .ctrl_mem_read_i(ctrl_mem_read_i),
    .ctrl_mem_write_i(ctrl_mem_write_i), .ctrl_ex_AluSrc_i(ctrl_ex_AluSrc_i),
    .ctrl_ex_AluOp_i(ctrl_ex_AluOp_i), .pc_i(pc_i), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .imm_data_i(imm_data_i), .alu_op_i(alu_op_i),
    .write_addr_i(write_addr_i), .valid_o(valid_o), .alu_result_o(alu_result_o),
    .zero_o(zero_o), .branch_target_o(branch_target_o), .store_data_o(store_data_o),
    .illegal_o(illegal_o), .ctrl_wb_RegWrite_o(ctrl_wb_RegWrite_o),
    .ctrl_wb_Mem2Reg_o(ctrl_wb_Mem2Reg_o), .ctrl_mem_branch_o(ctrl_mem_branch_o),
    .ctrl_mem_read_o(ctrl_mem_read_o), .ctrl_mem_write_o(ctrl_mem_write_o),
    .write_addr_o(write_addr_o)
  );

  // Reference model: the architectural result of each operation
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    p  = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return sa >>> b[4:0];
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic src);
    alu_op_i           = op;
    reg1_data_i        = a;
    reg2_data_i        = r2;
    imm_data_i         = imm;
    pc_i               = pc;
    ctrl_ex_AluSrc_i   = src;
    ctrl_ex_AluOp_i    = 2'($urandom);
    ctrl_wb_RegWrite_i = 1'($urandom);
    ctrl_wb_Mem2Reg_i  = 1'($urandom);
    ctrl_mem_branch_i  = 1'($urandom);
    ctrl_mem_read_i    = 1'($urandom);
    ctrl_mem_write_i   = 1'($urandom);
    write_addr_i       = 5'($urandom);
    valid_i            = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid_o, zero_o, illegal_o, ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
         ctrl_mem_read_o, ctrl_mem_write_o, write_addr_o} !== 13'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0", {valid_o, zero_o, illegal_o, ctrl_wb_RegWrite_o,
               ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o, ctrl_mem_read_o, ctrl_mem_write_o, write_addr_o});
    end
    checks++;
    if ({alu_result_o, branch_target_o, store_data_o} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h required 0", alu_result_o, branch_target_o, store_data_o);
    end
    checks++;
    if ({ready_o, stall_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b stall=%b required ready=1 stall=0", ready_o, stall_req_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed_alu;
    drive(4'd0, 32'd5, 32'($urandom), 32'hFFFF_FFFD, 32'h100, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({valid_o, zero_o, alu_result_o, branch_target_o} !== {1'b1, 1'b0, 32'd2, 32'hFD}) begin
      errors++;
      $display("FAIL add_imm: got v=%b z=%b r=%h bt=%h required v=1 z=0 r=2 bt=fd",
               valid_o, zero_o, alu_result_o, branch_target_o);
    end
    drive(4'd1, 32'd7, 32'd7, 32'($urandom), 32'($urandom), 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({valid_o, zero_o, alu_result_o} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL sub_zero: got v=%b z=%b r=%h required v=1 z=1 r=0", valid_o, zero_o, alu_result_o);
    end
    drive(4'd7, 32'h8000_0000, 32'd4, 32'($urandom), 32'($urandom), 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if ({valid_o, zero_o, alu_result_o} !== {1'b1, 1'b0, 32'hF800_0000}) begin
      errors++;
      $display("FAIL sra: got v=%b z=%b r=%h required v=1 z=0 r=f8000000", valid_o, zero_o, alu_result_o);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: got %b required 0", valid_o);
    end
  endtask

  task automatic test_random_alu;
    logic [3:0]  op;
    logic [31:0] a, r2, imm, pc, exp_r, exp_bt;
    logic        src;
    logic [4:0]  exp_ctl, exp_wa;
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 9));
      a   = $urandom;
      r2  = $urandom;
      imm = $urandom;
      pc  = $urandom;
      src = 1'($urandom);
      drive(op, a, r2, imm, pc, src);
      exp_r   = model(op, a, src ? imm : r2);
      exp_bt  = pc + imm;
      exp_ctl = {ctrl_wb_RegWrite_i, ctrl_wb_Mem2Reg_i, ctrl_mem_branch_i, ctrl_mem_read_i, ctrl_mem_write_i};
      exp_wa  = write_addr_i;
      @(posedge clk); #1;
      checks++;
      if ({valid_o, alu_result_o, zero_o} !== {1'b1, exp_r, exp_r == 32'd0}) begin
        errors++;
        $display("FAIL alu_rand op%0d: got v=%b r=%h z=%b required v=1 r=%h z=%b",
                 op, valid_o, alu_result_o, zero_o, exp_r, exp_r == 32'd0);
      end
      checks++;
      if ({branch_target_o, store_data_o} !== {exp_bt, r2}) begin
        errors++;
        $display("FAIL alu_rand_bt_sd: got %h %h required %h %h", branch_target_o, store_data_o, exp_bt, r2);
      end
      checks++;
      if ({ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o, ctrl_mem_read_o, ctrl_mem_write_o,
           write_addr_o, illegal_o} !== {exp_ctl, exp_wa, 1'b0}) begin
        errors++;
        $display("FAIL alu_rand_ctrl: got %b %h ill=%b required %b %h ill=0",
                 {ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o, ctrl_mem_read_o,
                  ctrl_mem_write_o}, write_addr_o, illegal_o, exp_ctl, exp_wa);
      end
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_muldiv;
    logic [3:0]  op;
    logic [31:0] a, b, exp_r;
    logic        exp_rw, exp_ill;
    logic [4:0]  exp_wa;
    int          lat, stalls, rdy_low, exp_lat, exp_stall, exp_rdy;
`ifdef RV32M_EN
    exp_lat = 33; exp_stall = 33; exp_rdy = 32; exp_ill = 1'b0;
`else
    exp_lat = 1; exp_stall = 0; exp_rdy = 0; exp_ill = 1'b1;
`endif
    for (int i = 0; i < 18; i++) begin
      case (i)
        0:  begin op = 4'd10; a = 32'hFFFF_FFFF; b = 32'd2; end
        1:  begin op = 4'd11; a = 32'hFFFF_FFFF; b = 32'd2; end
        2:  begin op = 4'd12; a = -32'sd7;       b = 32'd2; end
        3:  begin op = 4'd14; a = -32'sd7;       b = 32'd2; end
        4:  begin op = 4'd13; a = 32'd10;        b = 32'd0; end
        5:  begin op = 4'd15; a = 32'd10;        b = 32'd0; end
        6:  begin op = 4'd12; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        7:  begin op = 4'd14; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        8:  begin op = 4'd12; a = -32'sd7;       b = 32'd0; end
        9:  begin op = 4'd14; a = -32'sd7;       b = 32'd0; end
        default: begin
          op = 4'($urandom_range(10, 15));
          a  = $urandom;
          case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = -$urandom_range(1, 15);
            default: b = $urandom;
          endcase
        end
      endcase
      drive(op, a, b, 32'($urandom), 32'($urandom), 1'b0);
`ifdef RV32M_EN
      exp_r  = model(op, a, b);
      exp_rw = ctrl_wb_RegWrite_i;
`else
      exp_r  = 32'd0;
      exp_rw = 1'b0;
`endif
      exp_wa  = write_addr_i;
      lat     = 0;
      stalls  = 0;
      rdy_low = 0;
      #1;
      if (stall_req_o) stalls++;
      if (!ready_o) rdy_low++;
      @(posedge clk); #1;
      valid_i = 1'b0;
      #1;
      for (int k = 1; k <= 40; k++) begin
        if (valid_o === 1'b1) begin
          lat = k;
          break;
        end
        if (stall_req_o) stalls++;
        if (!ready_o) rdy_low++;
        @(posedge clk); #1;
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL mop_latency op%0d: got %0d required %0d", op, lat, exp_lat);
      end
      checks++;
      if ({alu_result_o, zero_o} !== {exp_r, exp_r == 32'd0}) begin
        errors++;
        $display("FAIL mop_result op%0d a=%h b=%h: got %h z=%b required %h", op, a, b, alu_result_o, zero_o, exp_r);
      end
      checks++;
      if ({illegal_o, ctrl_wb_RegWrite_o, write_addr_o} !== {exp_ill, exp_rw, exp_wa}) begin
        errors++;
        $display("FAIL mop_ctrl op%0d: got ill=%b rw=%b wa=%h required ill=%b rw=%b wa=%h",
                 op, illegal_o, ctrl_wb_RegWrite_o, write_addr_o, exp_ill, exp_rw, exp_wa);
      end
      checks++;
      if (stalls != exp_stall || rdy_low != exp_rdy) begin
        errors++;
        $display("FAIL mop_stall op%0d: got stall=%0d ready_low=%0d required %0d %0d",
                 op, stalls, rdy_low, exp_stall, exp_rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL mop_pulse op%0d: got valid=%b required 0", op, valid_o);
      end
    end
  endtask

  task automatic test_flush;
    int pulses;
`ifdef RV32M_EN
    int fc [2];
    fc[0] = 10;
    fc[1] = 32;
    for (int j = 0; j < 2; j++) begin
      drive(4'd10, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (fc[j] - 1) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      #1;
      checks++;
      if ({ready_o, stall_req_o, valid_o} !== 3'b100) begin
        errors++;
        $display("FAIL flush_busy%0d: got ready=%b stall=%b valid=%b required 1 0 0",
                 fc[j], ready_o, stall_req_o, valid_o);
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
        if (valid_o === 1'b1) pulses++;
        @(posedge clk); #1;
      end
      checks++;
      if (pulses != 0) begin
        errors++;
        $display("FAIL flush_no_result%0d: got %0d pulses required 0", fc[j], pulses);
      end
    end
`endif
    drive(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_valid: got valid=%b required 0", valid_o);
    end
    drive(4'd0, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if ({valid_o, alu_result_o} !== {1'b1, 32'd42}) begin
      errors++;
      $display("FAIL add_after_flush: got v=%b r=%h required v=1 r=2a", valid_o, alu_result_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy;
    int pulses;
    drive(4'd12, 32'd100, 32'd7, 32'h55, 32'h1000, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, zero_o, illegal_o, ctrl_wb_RegWrite_o, ctrl_wb_Mem2Reg_o, ctrl_mem_branch_o,
         ctrl_mem_read_o, ctrl_mem_write_o, write_addr_o, alu_result_o, branch_target_o, store_data_o} !== 109'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: got r=%h bt=%h sd=%h v=%b ill=%b wa=%h required all 0",
               alu_result_o, branch_target_o, store_data_o, valid_o, illegal_o, write_addr_o);
    end
    checks++;
    if ({ready_o, stall_req_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_busy_hs: got ready=%b stall=%b required 1 0", ready_o, stall_req_o);
    end
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_result: got %0d pulses required 0", pulses);
    end
    drive(4'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if ({valid_o, alu_result_o} !== {1'b1, 32'h00F0_1234}) begin
      errors++;
      $display("FAIL and_after_reset: got v=%b r=%h required v=1 r=00f01234", valid_o, alu_result_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed_alu;
    test_random_alu;
    test_muldiv;
    test_flush;
    test_reset_busy;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
